// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;

  localparam int OP_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Master index width, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Master-side request/response lanes plus the single muxed slave port.
interface bus_arbiter_rr_if #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
);
  import bus_arb_pkg::*;

  localparam int ID_W = id_w(N_MASTERS);
  localparam int BE_W = DATA_W / 8;

  // per-master request side
  logic [N_MASTERS-1:0]             i_bus_en;
  logic [N_MASTERS-1:0]             i_wr_rd;
  logic [N_MASTERS-1:0][DATA_W-1:0] i_wr_data;
  logic [N_MASTERS-1:0][ADDR_W-1:0] i_addr;
  logic [N_MASTERS-1:0][BE_W-1:0]   i_byte_en;
  logic [N_MASTERS-1:0]             i_atomic;
  logic [N_MASTERS-1:0][OP_W-1:0]   i_operation;
  logic [N_MASTERS-1:0]             o_ack;
  logic [N_MASTERS-1:0][DATA_W-1:0] o_rd_data;

  // shared slave side
  logic              i_ack;
  logic [DATA_W-1:0] i_rd_data;
  logic              o_bus_en;
  logic              o_wr_en;
  logic              o_atomic;
  logic [ID_W-1:0]   o_id;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [BE_W-1:0]   o_byte_en;
  logic [OP_W-1:0]   o_operation;

  // Arbiter view.
  modport slave (
    input  i_bus_en, i_wr_rd, i_wr_data, i_addr, i_byte_en, i_atomic, i_operation,
    input  i_ack, i_rd_data,
    output o_ack, o_rd_data,
    output o_bus_en, o_wr_en, o_atomic, o_id, o_addr, o_wr_data, o_byte_en, o_operation
  );

  // Requester / environment view.
  modport master (
    output i_bus_en, i_wr_rd, i_wr_data, i_addr, i_byte_en, i_atomic, i_operation,
    output i_ack, i_rd_data,
    input  o_ack, o_rd_data,
    input  o_bus_en, o_wr_en, o_atomic, o_id, o_addr, o_wr_data, o_byte_en, o_operation
  );

endinterface

// File: rtl/rr_picker.sv
// Cyclic first-requester search starting at ptr_i.
module rr_picker #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  // Walk offsets from far to near so the closest requester wins last.
  always_comb begin
    int j;
    j       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with atomic lock hold-off.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS    = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bus_arbiter_rr_if.slave bus
);

  localparam int ID_W  = id_w(N_MASTERS);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  g_q, g_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_vld;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  g_nxt;
  logic             req_g;

  rr_picker #(.N(N_MASTERS), .ID_W(ID_W)) u_pick (
    .req_i   (bus.i_bus_en),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign req_g = bus.i_bus_en[g_q];
  assign g_nxt = (g_q == ID_W'(N_MASTERS - 1)) ? '0 : g_q + 1'b1;

  // State, grant, pointer and lock counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant, complete, lock, abort and lock timeout.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          g_d     = pick_idx;
        end
      end
      ST_BUSY: begin
        // A withdrawn request aborts even if the slave acks the same cycle.
        if (!req_g) begin
          state_d = ST_IDLE;
        end else if (bus.i_ack) begin
          if (bus.i_atomic[g_q]) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            ptr_d   = g_nxt;
          end
        end
      end
      ST_LOCKED: begin
        if (req_g) begin
          state_d = ST_BUSY;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = g_nxt;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: mux granted master in BUSY, only o_id while LOCKED, zero otherwise.
  always_comb begin
    bus.o_bus_en    = 1'b0;
    bus.o_wr_en     = 1'b0;
    bus.o_atomic    = 1'b0;
    bus.o_id        = '0;
    bus.o_addr      = '0;
    bus.o_wr_data   = '0;
    bus.o_byte_en   = '0;
    bus.o_operation = '0;
    bus.o_ack       = '0;
    bus.o_rd_data   = '0;
    case (state_q)
      ST_BUSY: begin
        bus.o_bus_en    = req_g;
        bus.o_wr_en     = bus.i_wr_rd[g_q];
        bus.o_atomic    = bus.i_atomic[g_q];
        bus.o_id        = g_q;
        bus.o_addr      = bus.i_addr[g_q];
        bus.o_wr_data   = bus.i_wr_data[g_q];
        bus.o_byte_en   = bus.i_byte_en[g_q];
        bus.o_operation = bus.i_operation[g_q];
        // No ack for a withdrawn request or one being reset away.
        bus.o_ack[g_q]     = bus.i_ack & req_g & i_rst;
        bus.o_rd_data[g_q] = bus.i_rd_data;
      end
      ST_LOCKED: bus.o_id = g_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: expected grant order queued at stimulus time.
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LT = 8;
  localparam int BE = DW / 8;

  logic clk;
  logic rst;

  bus_arbiter_rr_if #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  bus_arbiter_rr #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .LOCK_TIMEOUT(LT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];
  bit hold[N];
  bit rel_pend[N];
  bit exp_wr[N];
  int ack_dly = 1;
  bit slave_en = 1'b1;
  bit force_ack = 1'b0;
  int wait_cnt = 0;
  bit prev_ack = 1'b0;

  function automatic logic [AW-1:0] m_addr(input int m);
    return AW'(32'h100 + m * 16);
  endfunction
  function automatic logic [DW-1:0] m_wdata(input int m);
    return DW'(32'hD000_0000 + m);
  endfunction
  function automatic logic [BE-1:0] m_be(input int m);
    return BE'(1 << m);
  endfunction
  function automatic logic [OP_W-1:0] m_op(input int m);
    return OP_W'(m + 5);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic req(input int m, input bit wr, input bit atom, input bit keep);
    bus.i_bus_en[m] = 1'b1;
    bus.i_wr_rd[m]  = wr;
    bus.i_atomic[m] = atom;
    exp_wr[m]       = wr;
    hold[m]         = keep;
  endtask

  // One clock: apply releases, slave response, then monitor mid-cycle.
  task automatic cyc();
    int e;
    @(negedge clk);
    for (int m = 0; m < N; m++) begin
      if (rel_pend[m]) begin
        bus.i_bus_en[m] = 1'b0;
        bus.i_atomic[m] = 1'b0;
        rel_pend[m]     = 1'b0;
      end
    end
    #1;
    if (bus.o_bus_en && slave_en) begin
      wait_cnt++;
      if (wait_cnt >= ack_dly) begin
        bus.i_ack = 1'b1;
        wait_cnt  = 0;
      end else begin
        bus.i_ack = 1'b0;
      end
    end else begin
      wait_cnt  = 0;
      bus.i_ack = force_ack;
    end
    bus.i_rd_data = bus.o_addr ^ 32'h5A5A_0000;
    #1;
    if (prev_ack) chk("bubble", 64'(bus.o_bus_en), 64'd0);
    prev_ack = |bus.o_ack;
    if (|bus.o_ack) begin
      if (sb_q.size() == 0) begin
        chk("extra_ack", 64'(bus.o_ack), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_vec", 64'(bus.o_ack), 64'd1 << e);
        chk("gnt_id", 64'(bus.o_id), 64'(e));
        chk("addr", 64'(bus.o_addr), 64'(m_addr(e)));
        chk("wdata", 64'(bus.o_wr_data), 64'(m_wdata(e)));
        chk("byte_en", 64'(bus.o_byte_en), 64'(m_be(e)));
        chk("op", 64'(bus.o_operation), 64'(m_op(e)));
        chk("wr_en", 64'(bus.o_wr_en), 64'(exp_wr[e]));
        for (int j = 0; j < N; j++)
          chk("rdata", 64'(bus.o_rd_data[j]),
              (j == e) ? 64'(m_addr(e) ^ 32'h5A5A_0000) : 64'd0);
      end
      for (int m = 0; m < N; m++)
        if (bus.o_ack[m] && !hold[m]) rel_pend[m] = 1'b1;
    end
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (sb_q.size() != 0 && c < max) begin
      cyc();
      c++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.i_bus_en  = '0;
    bus.i_atomic  = '0;
    bus.i_wr_rd   = '0;
    for (int m = 0; m < N; m++) begin
      hold[m]     = 1'b0;
      rel_pend[m] = 1'b0;
    end
    sb_q.delete();
    ack_dly   = 1;
    slave_en  = 1'b1;
    force_ack = 1'b0;
    repeat (2) cyc();
    rst      = 1'b1;
    prev_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.i_bus_en  = '0;
    bus.i_wr_rd   = '0;
    bus.i_atomic  = '0;
    bus.i_ack     = 1'b0;
    bus.i_rd_data = '0;
    for (int m = 0; m < N; m++) begin
      bus.i_addr[m]      = m_addr(m);
      bus.i_wr_data[m]   = m_wdata(m);
      bus.i_byte_en[m]   = m_be(m);
      bus.i_operation[m] = m_op(m);
    end

    // Reset state.
    repeat (2) cyc();
    chk("rst_bus_en", 64'(bus.o_bus_en), 64'd0);
    chk("rst_id", 64'(bus.o_id), 64'd0);
    chk("rst_ack", 64'(bus.o_ack), 64'd0);
    rst = 1'b1;
    cyc();
    chk("idle_bus_en", 64'(bus.o_bus_en), 64'd0);

    // Two simultaneous requesters from ptr=0: grant 0, bubble, grant 1.
    sb_q.push_back(0);
    sb_q.push_back(1);
    req(0, 1'b1, 1'b0, 1'b0);
    req(1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("lat_bus_en", 64'(bus.o_bus_en), 64'd1);
    chk("lat_id", 64'(bus.o_id), 64'd0);
    drain(20);
    repeat (2) cyc();

    // Four continuous requesters, slave acks after two cycles.
    do_reset();
    ack_dly = 2;
    foreach (sb_q[i]) sb_q.delete();
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    sb_q.push_back(3); sb_q.push_back(0);
    for (int m = 0; m < N; m++) req(m, m[0], 1'b0, 1'b1);
    drain(60);
    for (int m = 0; m < N; m++) begin
      hold[m]     = 1'b0;
      rel_pend[m] = 1'b1;
    end
    repeat (3) cyc();

    // Atomic read by master 2, master 0 waits, master 2 re-requests 3 cycles later.
    do_reset();
    sb_q.push_back(2);
    req(2, 1'b0, 1'b1, 1'b0);
    drain(10);
    sb_q.push_back(2);
    sb_q.push_back(0);
    req(0, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      cyc();
      chk("lock_id", 64'(bus.o_id), 64'd2);
      chk("lock_bus_en", 64'(bus.o_bus_en), 64'd0);
    end
    req(2, 1'b0, 1'b0, 1'b0);
    drain(20);
    repeat (2) cyc();

    // Atomic ack by master 1, no re-request: lock held LT cycles, then ptr=2.
    do_reset();
    sb_q.push_back(1);
    req(1, 1'b0, 1'b1, 1'b0);
    drain(10);
    for (int k = 0; k < LT; k++) begin
      cyc();
      chk("tmo_lock_id", 64'(bus.o_id), 64'd1);
    end
    cyc();
    chk("tmo_idle_id", 64'(bus.o_id), 64'd0);
    sb_q.push_back(2); sb_q.push_back(0); sb_q.push_back(1);
    req(0, 1'b1, 1'b0, 1'b0);
    req(1, 1'b0, 1'b0, 1'b0);
    req(2, 1'b1, 1'b0, 1'b0);
    drain(40);
    repeat (2) cyc();

    // Abort mid-BUSY leaves ptr alone; spurious acks in IDLE are ignored.
    do_reset();
    sb_q.push_back(0);
    req(0, 1'b1, 1'b0, 1'b0);
    drain(10);
    slave_en = 1'b0;
    req(2, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("abort_busy_id", 64'(bus.o_id), 64'd2);
    chk("abort_busy_ack", 64'(bus.o_ack), 64'd0);
    bus.i_bus_en[2] = 1'b0;
    cyc();
    chk("abort_idle_en", 64'(bus.o_bus_en), 64'd0);
    chk("abort_idle_ack", 64'(bus.o_ack), 64'd0);
    force_ack = 1'b1;
    repeat (3) begin
      cyc();
      chk("spur_ack", 64'(bus.o_ack), 64'd0);
      chk("spur_bus_en", 64'(bus.o_bus_en), 64'd0);
    end
    force_ack = 1'b0;
    slave_en  = 1'b1;
    sb_q.push_back(1);
    sb_q.push_back(0);
    req(0, 1'b0, 1'b0, 1'b0);
    req(1, 1'b1, 1'b0, 1'b0);
    drain(30);
    repeat (2) cyc();

    // Reset asserted while BUSY with the slave acking.
    do_reset();
    slave_en = 1'b0;
    req(3, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("rb_busy_id", 64'(bus.o_id), 64'd3);
    rst       = 1'b0;
    force_ack = 1'b1;
    cyc();
    cyc();
    chk("rb_ack", 64'(bus.o_ack), 64'd0);
    chk("rb_bus_en", 64'(bus.o_bus_en), 64'd0);
    chk("rb_id", 64'(bus.o_id), 64'd0);
    bus.i_bus_en[3] = 1'b0;
    force_ack       = 1'b0;
    rst             = 1'b1;
    repeat (2) cyc();
    chk("rb_after_en", 64'(bus.o_bus_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
